fp24_int_cvt: RTL

- Pipelined format converter between signed 32-bit integers and the core's 24-bit float format: sign [23], exponent [22:15] with bias 127, mantissa [14:0] with an implicit leading 1.
- Feeds integer operands into the fp24 add/sub/min/max datapath and returns fp24 results to the integer side, e.g. texel/vertex index math.
- Two-stage pipeline with valid/ready handshakes on both sides; throughput is one conversion per cycle.

---
 rtl/fp24_pkg.sv | 27 ++
 rtl/fp24_int_cvt_lzc32.sv | 17 +
 rtl/fp24_int_cvt.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fp24_pkg.sv
// Shared definitions for the fp24 format: field widths, bit positions,
// the packed fp24 struct and the conversion opcode.
package fp24_pkg;

    localparam int FP_W     = 24;
    localparam int EXP_W    = 8;
    localparam int MANT_W   = 15;
    localparam int EXP_BIAS = 127;

    localparam int SIGN_POS = 23;
    localparam int EXP_MSB  = 22;
    localparam int EXP_LSB  = 15;
    localparam int MANT_MSB = 14;
    localparam int MANT_LSB = 0;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp24_t;

    typedef enum logic {
        CVT_I2F = 1'b0,
        CVT_F2I = 1'b1
    } cvt_op_e;

endpackage

// File: rtl/fp24_int_cvt_lzc32.sv
// Combinational 32-bit leading-zero counter; an all-zero input reports 32.
module lzc32 (
    input  logic [31:0] value,
    output logic [5:0]  count
);

    // Scan upward so the final hit is the most significant set bit
    always_comb begin
        count = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (value[i]) begin
                count = 6'(31 - i);
            end
        end
    end

endmodule

// File: rtl/fp24_int_cvt.sv
// Two-stage int32 <-> fp24 converter with valid/ready on both sides.
// Stage 1 decodes the operand (magnitude, leading zeros, exponent);
// stage 2 shifts, negates and packs into the registered outputs.
module fp24_int_cvt
    import fp24_pkg::*;
#(
    parameter int INT_W    = 32,
    parameter int FP_W     = 24,
    parameter int EXP_BIAS = 127
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             in_op_i,
    input  logic [INT_W-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [INT_W-1:0] out_data_o,
    output logic             out_sat_o,
    output logic             out_inexact_o
);

    logic             v1;
    logic             v2;
    logic             adv2;

    cvt_op_e          s1_op;
    logic             s1_sign;
    logic [INT_W-1:0] s1_mag;
    logic [5:0]       s1_lz;
    logic [EXP_W-1:0] s1_exp;
    logic             s1_zero;
    logic             s1_nz;
    logic             s1_sat;

    fp24_t            in_fp;
    logic [INT_W-1:0] in_abs;
    logic [5:0]       in_lz;

    logic [INT_W-1:0]   i2f_norm;
    fp24_t              i2f_res;
    logic [5:0]         f2i_sh;
    logic [2*INT_W-1:0] f2i_fix;
    logic [INT_W-1:0]   f2i_int;

    logic [INT_W-1:0] res_data;
    logic             res_sat;
    logic             res_inexact;

    assign adv2        = !v2 || out_ready_i;
    assign in_ready_o  = !v1 || adv2;
    assign out_valid_o = v2;

    assign in_fp  = fp24_t'(in_data_i[FP_W-1:0]);
    assign in_abs = in_data_i[INT_W-1] ? (~in_data_i + 1'b1) : in_data_i;

    lzc32 u_lzc (
        .value (in_abs),
        .count (in_lz)
    );

    // Stage 1: capture the decoded operand whenever the slot is free to accept
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1      <= 1'b0;
            s1_op   <= CVT_I2F;
            s1_sign <= 1'b0;
            s1_mag  <= '0;
            s1_lz   <= '0;
            s1_exp  <= '0;
            s1_zero <= 1'b0;
            s1_nz   <= 1'b0;
            s1_sat  <= 1'b0;
        end else if (in_ready_o) begin
            v1 <= in_valid_i;
            if (in_valid_i) begin
                s1_op <= cvt_op_e'(in_op_i);
                if (in_op_i) begin
                    s1_sign <= in_fp.sign;
                    s1_mag  <= {16'b0, 1'b1, in_fp.mant};
                    s1_lz   <= '0;
                    s1_exp  <= in_fp.exp - EXP_W'(EXP_BIAS);
                    s1_zero <= in_fp.exp < EXP_W'(EXP_BIAS);
                    s1_nz   <= |{in_fp.exp, in_fp.mant};
                    s1_sat  <= in_fp.exp >= EXP_W'(EXP_BIAS + INT_W - 1);
                end else begin
                    s1_sign <= in_data_i[INT_W-1];
                    s1_mag  <= in_abs;
                    s1_lz   <= in_lz;
                    s1_exp  <= EXP_W'(EXP_BIAS + INT_W - 1) - {2'b0, in_lz};
                    s1_zero <= 1'b0;
                    s1_nz   <= 1'b0;
                    s1_sat  <= 1'b0;
                end
            end
        end
    end

    assign i2f_norm = s1_mag << s1_lz;
    assign i2f_res  = {s1_sign, s1_exp, i2f_norm[INT_W-2 -: MANT_W]};

    // The fixed-point view puts the binary point at bit 32, so the upper half
    // is the integer part and any set bit in the lower half was truncated
    assign f2i_sh  = {1'b0, s1_exp[4:0]} + 6'd17;
    assign f2i_fix = {{INT_W{1'b0}}, s1_mag} << f2i_sh;
    assign f2i_int = f2i_fix[2*INT_W-1:INT_W];

    // Stage 2 result selection: pack the float or negate/saturate the integer
    always_comb begin
        res_data    = '0;
        res_sat     = 1'b0;
        res_inexact = 1'b0;
        if (s1_op == CVT_I2F) begin
            if (i2f_norm[INT_W-1]) begin
                res_data    = {{(INT_W-FP_W){1'b0}}, i2f_res};
                res_inexact = |i2f_norm[15:0];
            end
        end else if (s1_zero) begin
            res_inexact = s1_nz;
        end else if (s1_sat) begin
            res_sat  = 1'b1;
            res_data = s1_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            res_data    = s1_sign ? (~f2i_int + 1'b1) : f2i_int;
            res_inexact = |f2i_fix[INT_W-1:0];
        end
    end

    // Stage 2: output register, held while the consumer stalls
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v2            <= 1'b0;
            out_data_o    <= '0;
            out_sat_o     <= 1'b0;
            out_inexact_o <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                out_data_o    <= res_data;
                out_sat_o     <= res_sat;
                out_inexact_o <= res_inexact;
            end
        end
    end

endmodule
